mmc3_scanline_irq: RTL and testbench

- MMC3-style scanline IRQ counter for the multicart mapper logic.
- Sits between the PPU address bus and the cartridge `irq` pin.
- Consumes the PPU A12 line and the decoded CPU writes to $C000/$C001/$E000/$E001, and produces the active-low IRQ the top level drives out.
- Runs on the CPU M2 clock and filters A12 so that only one edge per scanline is counted.

---
 rtl/mmc3_scanline_irq.sv | 74 +++++++
 tb/tb_mmc3_scanline_irq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3-style scanline IRQ counter clocked by filtered PPU A12 rises.
module mmc3_scanline_irq #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int ALT_IRQ       = 0
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       ppu_a12,
  input  logic       reg_write,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  output logic       irq_n,
  output logic [7:0] counter,
  output logic       a12_clock
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic       a12_dly_q, a12_dly_d;
  logic [2:0] low_cnt_q, low_cnt_d;
  logic [7:0] latch_q, latch_d, counter_q, counter_d;
  logic       reload_q, reload_d, enable_q, enable_d, pending_q, pending_d;
  logic       irq_n_q, irq_n_d, a12_clock_q, a12_clock_d;
  logic       a12_s, rise, reload_now, irq_hit;
  logic [7:0] next_cnt;
  logic [3:0] wr;
  always_comb begin
    a12_s       = sync_q[SYNC_STAGES-1];
    sync_d      = {sync_q[SYNC_STAGES-2:0], ppu_a12};
    a12_dly_d   = a12_s;
    low_cnt_d   = a12_s ? 3'd0 : low_cnt_q + 3'(low_cnt_q != 3'd7);
    rise        = a12_s & ~a12_dly_q & (low_cnt_q >= 3'(FILTER_CYCLES));
    reload_now  = (counter_q == 8'd0) | reload_q;
    next_cnt    = reload_now ? latch_q : counter_q - 8'd1;
    // old-style MMC3 ignores an idle counter reloading to a zero latch
    irq_hit     = rise & enable_q & (next_cnt == 8'd0) &
                  ((ALT_IRQ == 0) | (counter_q != 8'd0) | reload_q);
    wr          = reg_write ? 4'b0001 << reg_sel : 4'b0000;
    latch_d     = wr[0] ? reg_data : latch_q;
    counter_d   = wr[1] ? 8'd0 : rise ? next_cnt : counter_q;
    reload_d    = wr[1] | (reload_q & ~rise);
    enable_d    = wr[3] | (enable_q & ~wr[2]);
    pending_d   = ~wr[2] & (pending_q | irq_hit);
    irq_n_d     = ~pending_q;
    a12_clock_d = rise;
  end
  always_ff @(posedge m2) begin
    if (reset) begin
      sync_q      <= '0;
      a12_dly_q   <= 1'b0;
      low_cnt_q   <= 3'd0;
      latch_q     <= 8'd0;
      counter_q   <= 8'd0;
      reload_q    <= 1'b0;
      enable_q    <= 1'b0;
      pending_q   <= 1'b0;
      irq_n_q     <= 1'b1;
      a12_clock_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      a12_dly_q   <= a12_dly_d;
      low_cnt_q   <= low_cnt_d;
      latch_q     <= latch_d;
      counter_q   <= counter_d;
      reload_q    <= reload_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      irq_n_q     <= irq_n_d;
      a12_clock_q <= a12_clock_d;
    end
  end
  assign irq_n     = irq_n_q;
  assign counter   = counter_q;
  assign a12_clock = a12_clock_q;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: directed + random A12/register stimulus against a per-cycle reference model, both IRQ modes.
module tb_mmc3_scanline_irq;
  localparam int S = 2;
  localparam int F = 3;
  logic m2 = 1'b0;
  logic reset = 1'b1, ppu_a12 = 1'b0, reg_write = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_data = 8'd0;
  logic irq_n0, irq_n1, clk0, clk1;
  logic [7:0] counter0, counter1;
  int vectors = 0, fails = 0;
  bit pipe [S];
  int run;
  int m_latch [2], m_cnt [2];
  bit m_rel [2], m_en [2], m_pend [2], m_irqn [2], m_clk [2];

  mmc3_scanline_irq #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .ALT_IRQ(0)) dut0 (
    .m2(m2), .reset(reset), .ppu_a12(ppu_a12), .reg_write(reg_write), .reg_sel(reg_sel),
    .reg_data(reg_data), .irq_n(irq_n0), .counter(counter0), .a12_clock(clk0));
  mmc3_scanline_irq #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .ALT_IRQ(1)) dut1 (
    .m2(m2), .reset(reset), .ppu_a12(ppu_a12), .reg_write(reg_write), .reg_sel(reg_sel),
    .reg_data(reg_data), .irq_n(irq_n1), .counter(counter1), .a12_clock(clk1));

  always #5 m2 = ~m2;

  task automatic model(input bit rst, input bit a12, input bit wr, input logic [1:0] sel, input logic [7:0] d);
    bit s, q, idle;
    int nc;
    if (rst) begin
      for (int i = 0; i < S; i++) pipe[i] = 1'b0;
      run = 0;
      for (int m = 0; m < 2; m++) begin
        m_latch[m] = 0; m_cnt[m] = 0; m_rel[m] = 0; m_en[m] = 0;
        m_pend[m] = 0; m_irqn[m] = 1; m_clk[m] = 0;
      end
      return;
    end
    // a rise counts when A12, seen through the synchroniser, follows at least F low cycles
    s = pipe[S-1];
    q = s && run >= F;
    run = s ? 0 : run + 1;
    for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = a12;
    for (int m = 0; m < 2; m++) begin
      m_irqn[m] = !m_pend[m];
      m_clk[m] = q;
      if (q) begin
        idle = (m_cnt[m] == 0) && !m_rel[m];
        nc = (m_cnt[m] == 0 || m_rel[m]) ? m_latch[m] : m_cnt[m] - 1;
        if (m_en[m] && nc == 0 && (m == 0 || !idle)) m_pend[m] = 1;
        m_cnt[m] = nc;
        m_rel[m] = 0;
      end
      if (wr)
        case (sel)
          2'd0: m_latch[m] = d;
          2'd1: begin m_cnt[m] = 0; m_rel[m] = 1; end
          2'd2: begin m_en[m] = 0; m_pend[m] = 0; end
          default: m_en[m] = 1;
        endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit a12, input bit wr, input logic [1:0] sel, input logic [7:0] d);
    reset = rst; ppu_a12 = a12; reg_write = wr; reg_sel = sel; reg_data = d;
    @(posedge m2);
    model(rst, a12, wr, sel, d);
    @(negedge m2);
    chk("counter0", counter0, 8'(m_cnt[0]));
    chk("irq_n0", {7'd0, irq_n0}, {7'd0, m_irqn[0]});
    chk("a12_clock0", {7'd0, clk0}, {7'd0, m_clk[0]});
    chk("counter1", counter1, 8'(m_cnt[1]));
    chk("irq_n1", {7'd0, irq_n1}, {7'd0, m_irqn[1]});
    chk("a12_clock1", {7'd0, clk1}, {7'd0, m_clk[1]});
  endtask

  task automatic lvl(input bit a12, input int n);
    for (int i = 0; i < n; i++) step(0, a12, 0, 2'd0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    step(0, 0, 1, sel, d);
  endtask

  task automatic line();
    lvl(0, 8);
    lvl(1, 4);
  endtask

  initial begin
    model(1, 0, 0, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd0, 8'd0);
    wr(2'd0, 8'd3); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    for (int i = 0; i < 4; i++) line();
    wr(2'd2, 8'd0);
    line();
    lvl(0, 2); lvl(1, 4);
    lvl(0, 3); lvl(1, 4);
    wr(2'd0, 8'd0);
    for (int i = 0; i < 2; i++) line();
    wr(2'd2, 8'd0); wr(2'd3, 8'd0);
    line();
    wr(2'd2, 8'd0); wr(2'd3, 8'd0); wr(2'd1, 8'd0);
    line();
    wr(2'd2, 8'd0); wr(2'd0, 8'd5); wr(2'd1, 8'd0);
    line();
    wr(2'd0, 8'd7);
    lvl(0, 8); lvl(1, 2);
    step(0, 1, 1, 2'd1, 8'd0);
    lvl(1, 1);
    line();
    wr(2'd0, 8'd1); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    line(); line();
    wr(2'd0, 8'd2);
    line();
    lvl(0, 3);
    step(1, 0, 0, 2'd0, 8'd0);
    lvl(0, 1); lvl(1, 4);
    line();
    for (int i = 0; i < 200; i++) begin
      int lo, hi;
      lo = $urandom_range(0, 9);
      hi = $urandom_range(1, 6);
      for (int j = 0; j < lo + hi; j++)
        step(($urandom % 400) == 0, j >= lo, ($urandom % 6) == 0, 2'($urandom),
             8'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
